// File: rtl/pwm_audio_output.sv
// pwm_audio_output: per-channel gain ramp and soft mute, error-feedback requantiser
// to PWM_N bits, and glitch-free PWM with staged codes transferred at carrier start.
module pwm_audio_output #(
   parameter int CHANNELS  = 2,
   parameter int SAMPLE_N  = 16,
   parameter int VOLUME_N  = 16,
   parameter int PWM_N     = 7,
   parameter int RAMP_STEP = 64
) (
   input  logic                         Clk,
   input  logic                         nReset,
   input  logic                         Sample_Ena,
   input  logic [CHANNELS*SAMPLE_N-1:0] Audio,
   input  logic [CHANNELS*VOLUME_N-1:0] Volume,
   input  logic                         Mute,
   input  logic                         Active,
   input  logic                         PWM_Ena,
   output logic [CHANNELS-1:0]          PWM_Out,
   output logic                         Busy,
   output logic                         Muted,
   output logic                         Overrun
);
   localparam int P  = SAMPLE_N + VOLUME_N;
   localparam int R  = P - PWM_N;
   localparam int IW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
   localparam logic [IW-1:0]       LAST = IW'(CHANNELS - 1);
   localparam logic [VOLUME_N-1:0] STEP = VOLUME_N'(RAMP_STEP);
   localparam logic [PWM_N-1:0]    MID  = {1'b1, {(PWM_N-1){1'b0}}};

   typedef enum logic {IDLE, MUL} state_t;

   state_t                       state_q, state_d;
   logic [IW-1:0]                idx_q, idx_d;
   logic [CHANNELS*SAMPLE_N-1:0] shadow_q, shadow_d;
   logic [VOLUME_N-1:0]          gain_q [CHANNELS];
   logic [VOLUME_N-1:0]          gain_d [CHANNELS];
   logic [R-1:0]                 res_q [CHANNELS];
   logic [R-1:0]                 res_d [CHANNELS];
   logic [PWM_N-1:0]             stage_q [CHANNELS];
   logic [PWM_N-1:0]             stage_d [CHANNELS];
   logic [PWM_N-1:0]             live_q [CHANNELS];
   logic [PWM_N-1:0]             live_d [CHANNELS];
   logic [PWM_N-1:0]             cnt_q, cnt_d;
   logic [CHANNELS-1:0]          pwm_q, pwm_d;
   logic                         busy_q, busy_d, muted_q, muted_d, overrun_q, overrun_d;

   logic signed [SAMPLE_N-1:0]   smp;
   logic [VOLUME_N-1:0]          gain, tgt;
   logic signed [P:0]            a_x, b_x, prod;
   logic [P:0]                   sum;
   logic [P-1:0]                 sat, ob;
   logic                         accept, zero;

   always_comb begin
      smp      = shadow_q[idx_q*SAMPLE_N +: SAMPLE_N];
      gain     = gain_q[idx_q];
      a_x      = {{(VOLUME_N+1){smp[SAMPLE_N-1]}}, smp};
      b_x      = {{(SAMPLE_N+1){1'b0}}, gain};
      prod     = a_x * b_x;
      // residual is non-negative, so only positive overflow is possible
      sum      = prod + {{(PWM_N+1){1'b0}}, res_q[idx_q]};
      sat      = (sum[P] != sum[P-1]) ? {1'b0, {(P-1){1'b1}}} : sum[P-1:0];
      ob       = {~sat[P-1], sat[P-2:0]};
      accept   = Sample_Ena && state_q == IDLE;
      state_d  = state_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      gain_d   = gain_q;
      res_d    = res_q;
      stage_d  = stage_q;
      tgt      = '0;
      zero     = 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
         tgt  = Mute ? '0 : Volume[c*VOLUME_N +: VOLUME_N];
         zero = zero & (gain_q[c] == '0);
         if (accept)
            gain_d[c] = (gain_q[c] < tgt) ? ((tgt - gain_q[c] > STEP) ? gain_q[c] + STEP : tgt)
                                          : ((gain_q[c] - tgt > STEP) ? gain_q[c] - STEP : tgt);
         live_d[c] = PWM_Ena ? stage_q[c] : live_q[c];
         pwm_d[c]  = Active & (live_q[c] > cnt_q);
      end
      if (state_q == MUL) begin
         stage_d[idx_q] = ob[P-1 -: PWM_N];
         res_d[idx_q]   = ob[R-1:0];
         idx_d          = idx_q + 1'b1;
         state_d        = (idx_q == LAST) ? IDLE : MUL;
      end
      if (accept) begin
         shadow_d = Audio;
         idx_d    = '0;
         state_d  = MUL;
      end
      cnt_d     = PWM_Ena ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
      busy_d    = state_d == MUL;
      muted_d   = Mute & zero;
      overrun_d = Sample_Ena & (state_q == MUL);
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         shadow_q  <= '0;
         gain_q    <= '{default: '0};
         res_q     <= '{default: '0};
         stage_q   <= '{default: MID};
         live_q    <= '{default: MID};
         cnt_q     <= '0;
         pwm_q     <= '0;
         busy_q    <= 1'b0;
         muted_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
         gain_q    <= gain_d;
         res_q     <= res_d;
         stage_q   <= stage_d;
         live_q    <= live_d;
         cnt_q     <= cnt_d;
         pwm_q     <= pwm_d;
         busy_q    <= busy_d;
         muted_q   <= muted_d;
         overrun_q <= overrun_d;
      end
   end

   assign PWM_Out = pwm_q;
   assign Busy    = busy_q;
   assign Muted   = muted_q;
   assign Overrun = overrun_q;
endmodule

// File: tb/tb_pwm_audio_output.sv
// tb_pwm_audio_output: scoreboard bench; expected PWM codes come from an integer model
// of the ramp/requantiser and are checked as high-cycle counts over a carrier period.
module tb_pwm_audio_output;
   localparam int CH = 2, SN = 16, VN = 16;

   logic             Clk = 1'b0, nReset = 1'b0, Sample_Ena = 1'b0;
   logic             Mute = 1'b0, Active = 1'b1, PWM_Ena = 1'b0;
   logic [CH*SN-1:0] Audio = '0;
   logic [CH*VN-1:0] Volume = '0;
   logic [CH-1:0]    PWM_Out;
   logic             Busy, Muted, Overrun;

   int     passed = 0, total = 0;
   longint gain_m [CH];
   longint res_m [CH];
   int     stage_m [CH];
   int     exp_q [$];
   int     got [CH];
   int     busy_cnt;
   logic   flags_seen, m0, m1;

   pwm_audio_output dut (
      .Clk(Clk), .nReset(nReset), .Sample_Ena(Sample_Ena), .Audio(Audio), .Volume(Volume),
      .Mute(Mute), .Active(Active), .PWM_Ena(PWM_Ena), .PWM_Out(PWM_Out), .Busy(Busy),
      .Muted(Muted), .Overrun(Overrun)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic void model_reset();
      for (int c = 0; c < CH; c++) begin
         gain_m[c]  = 0;
         res_m[c]   = 0;
         stage_m[c] = 64;
      end
   endfunction

   function automatic void model_accept(input logic [CH*SN-1:0] a, input logic [CH*VN-1:0] v, input logic m);
      for (int c = 0; c < CH; c++) begin
         longint tgt, s, sum;
         tgt = m ? 64'sd0 : longint'(v[c*VN +: VN]);
         if (gain_m[c] < tgt) gain_m[c] = (tgt - gain_m[c] > 64) ? gain_m[c] + 64 : tgt;
         else gain_m[c] = (gain_m[c] - tgt > 64) ? gain_m[c] - 64 : tgt;
         s   = longint'($signed(a[c*SN +: SN]));
         sum = s * gain_m[c] + res_m[c];
         if (sum > 64'sd2147483647) sum = 64'sd2147483647;
         sum        = sum + 64'sd2147483648;
         stage_m[c] = int'(sum >> 25);
         res_m[c]   = sum & 64'h1FF_FFFF;
      end
   endfunction

   task automatic do_sample(input logic [CH*SN-1:0] a, input logic [CH*VN-1:0] v, input logic m);
      Audio = a; Volume = v; Mute = m; Sample_Ena = 1'b1;
      model_accept(a, v, m);
      tick();
      Sample_Ena = 1'b0;
      m0 = Muted;
      busy_cnt = int'(Busy);
      tick();
      m1 = Muted;
      busy_cnt += int'(Busy);
      for (int i = 0; i < 6 && Busy; i++) begin
         tick();
         busy_cnt += int'(Busy);
      end
   endtask

   // Pulses PWM_Ena (optionally with a coincident sample) and counts high cycles per channel.
   task automatic measure(input int off, input bit with_sample, input logic [CH*SN-1:0] a, input logic [CH*VN-1:0] v);
      PWM_Ena = 1'b1;
      Active  = (off == 0);
      for (int c = 0; c < CH; c++) exp_q.push_back(off >= stage_m[c] ? 0 : stage_m[c] - off);
      if (with_sample) begin
         Audio = a; Volume = v; Mute = 1'b0; Sample_Ena = 1'b1;
         model_accept(a, v, 1'b0);
      end
      tick();
      PWM_Ena = 1'b0;
      Sample_Ena = 1'b0;
      flags_seen = 1'b0;
      for (int c = 0; c < CH; c++) got[c] = 0;
      for (int i = 1; i <= 128; i++) begin
         tick();
         for (int c = 0; c < CH; c++) got[c] += int'(PWM_Out[c]);
         flags_seen = flags_seen | Busy | Muted | Overrun;
         if (i == off) Active = 1'b1;
      end
      Active = 1'b1;
   endtask

   task automatic test_reset();
      nReset = 1'b0;
      model_reset();
      tick(); tick();
      total++;
      if ({PWM_Out, Busy, Muted, Overrun} !== 5'b0)
         $display("FAIL reset_outputs: got %b, expected 00000", {PWM_Out, Busy, Muted, Overrun});
      else passed++;
      nReset = 1'b1;
      for (int r = 0; r < 2; r++) begin
         measure(0, 1'b0, '0, '0);
         for (int c = 0; c < CH; c++) begin
            int e = exp_q.pop_front();
            total++;
            if (got[c] !== e) $display("FAIL reset_midscale ch%0d: got %0d high cycles, expected %0d", c, got[c], e);
            else passed++;
         end
         total++;
         if (flags_seen !== 1'b0) $display("FAIL idle_flags: got %b, expected 0", flags_seen);
         else passed++;
      end
   endtask

   task automatic test_full_scale();
      logic [CH*SN-1:0] a = {16'h8000, 16'h7FFF};
      logic [CH*VN-1:0] v = {2{16'hFFFF}};
      int bad = 0;
      for (int k = 0; k < 1100 && (gain_m[0] != 65535 || gain_m[1] != 65535); k++) begin
         do_sample(a, v, 1'b0);
         if (busy_cnt != 2) bad++;
      end
      total++;
      if (bad !== 0) $display("FAIL busy_width: got %0d strobes with Busy width != 2, expected 0", bad);
      else passed++;
      measure(0, 1'b0, '0, '0);
      for (int c = 0; c < CH; c++) begin
         int e = exp_q.pop_front();
         total++;
         if (got[c] !== e) $display("FAIL full_scale ch%0d: got %0d high cycles, expected %0d", c, got[c], e);
         else passed++;
      end
      total++;
      if (got[0] !== 127) $display("FAIL full_scale_max: got %0d, expected 127", got[0]);
      else passed++;
   endtask

   task automatic test_mute();
      logic [CH*SN-1:0] a = {16'h8000, 16'h7FFF};
      logic [CH*VN-1:0] v = {2{16'h1000}};
      for (int k = 0; k < 1100 && (gain_m[0] != 4096 || gain_m[1] != 4096); k++) do_sample(a, v, 1'b0);
      measure(0, 1'b0, '0, '0);
      for (int c = 0; c < CH; c++) begin
         int e = exp_q.pop_front();
         total++;
         if (got[c] !== e) $display("FAIL vol_1000 ch%0d: got %0d high cycles, expected %0d", c, got[c], e);
         else passed++;
      end
      for (int k = 1; k <= 64; k++) begin
         do_sample(a, v, 1'b1);
         if (k == 63) begin
            total++;
            if (Muted !== 1'b0) $display("FAIL muted_early: got %b, expected 0", Muted);
            else passed++;
         end
      end
      total++;
      if ({m0, m1} !== 2'b01) $display("FAIL muted_rise: got %b, expected 01", {m0, m1});
      else passed++;
      measure(0, 1'b0, '0, '0);
      for (int c = 0; c < CH; c++) begin
         int e = exp_q.pop_front();
         total++;
         if (got[c] !== e) $display("FAIL muted_codes ch%0d: got %0d high cycles, expected %0d", c, got[c], e);
         else passed++;
      end
      do_sample(a, v, 1'b0);
      total++;
      if (m0 !== 1'b0) $display("FAIL muted_fall: got %b, expected 0", m0);
      else passed++;
      for (int k = 1; k < 64; k++) do_sample(a, v, 1'b0);
      measure(0, 1'b0, '0, '0);
      for (int c = 0; c < CH; c++) begin
         int e = exp_q.pop_front();
         total++;
         if (got[c] !== e) $display("FAIL unmute_codes ch%0d: got %0d high cycles, expected %0d", c, got[c], e);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      logic [CH*SN-1:0] a1 = {16'h2000, 16'hE000};
      logic [CH*SN-1:0] a2 = {16'h7FFF, 16'h8000};
      logic [CH*VN-1:0] v = {2{16'h1000}};
      Audio = a1; Volume = v; Mute = 1'b0; Sample_Ena = 1'b1;
      model_accept(a1, v, 1'b0);
      tick();
      Audio = a2;
      total++;
      if ({Overrun, Busy} !== 2'b01) $display("FAIL b2b_first: got %b, expected 01", {Overrun, Busy});
      else passed++;
      tick();
      Sample_Ena = 1'b0;
      total++;
      if (Overrun !== 1'b1) $display("FAIL overrun_pulse: got %b, expected 1", Overrun);
      else passed++;
      tick();
      total++;
      if ({Overrun, Busy} !== 2'b00) $display("FAIL overrun_clear: got %b, expected 00", {Overrun, Busy});
      else passed++;
      measure(0, 1'b0, '0, '0);
      for (int c = 0; c < CH; c++) begin
         int e = exp_q.pop_front();
         total++;
         if (got[c] !== e) $display("FAIL b2b_codes ch%0d: got %0d high cycles, expected %0d", c, got[c], e);
         else passed++;
      end
   endtask

   task automatic test_active();
      logic [CH*SN-1:0] a = {16'h7FFF, 16'h7FFF};
      logic [CH*VN-1:0] v = {2{16'hFFFF}};
      int offs [3] = '{128, 10, 0};
      for (int k = 0; k < 1100 && (gain_m[0] != 65535 || gain_m[1] != 65535); k++) do_sample(a, v, 1'b0);
      for (int t = 0; t < 3; t++) begin
         measure(offs[t], 1'b0, '0, '0);
         for (int c = 0; c < CH; c++) begin
            int e = exp_q.pop_front();
            total++;
            if (got[c] !== e)
               $display("FAIL active_off%0d ch%0d: got %0d high cycles, expected %0d", offs[t], c, got[c], e);
            else passed++;
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [CH*SN-1:0] a = {16'h8000, 16'h7FFF};
      logic [CH*SN-1:0] b = {16'h7FFF, 16'h8000};
      logic [CH*VN-1:0] v = {2{16'hFFFF}};
      Audio = b; Sample_Ena = 1'b1;
      tick();
      Sample_Ena = 1'b0;
      #2 nReset = 1'b0;
      #1;
      total++;
      if ({PWM_Out, Busy, Muted, Overrun} !== 5'b0)
         $display("FAIL async_reset: got %b, expected 00000", {PWM_Out, Busy, Muted, Overrun});
      else passed++;
      model_reset();
      tick();
      nReset = 1'b1;
      measure(0, 1'b0, '0, '0);
      for (int c = 0; c < CH; c++) begin
         int e = exp_q.pop_front();
         total++;
         if (got[c] !== e) $display("FAIL reset_abort ch%0d: got %0d high cycles, expected %0d", c, got[c], e);
         else passed++;
      end
      for (int k = 0; k < 40; k++) do_sample(a, v, 1'b0);
      for (int t = 0; t < 2; t++) begin
         measure(0, t == 0, b, v);
         for (int c = 0; c < CH; c++) begin
            int e = exp_q.pop_front();
            total++;
            if (got[c] !== e) $display("FAIL coincident_%0d ch%0d: got %0d high cycles, expected %0d", t, c, got[c], e);
            else passed++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_scale();
      test_mute();
      test_back_to_back();
      test_active();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
